fft_capture_sequencer: RTL and testbench

//   Sequences sample capture for the FFT. Generates the sample-rate enable for the decimator,

---
 rtl/fft_pkg.sv | 16 +
 rtl/fft_capture_sequencer_ce_divider.sv | 31 +++
 rtl/fft_capture_sequencer.sv | 127 ++++++++++++
 tb/tb_fft_capture_sequencer.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared state encoding and defaults
// for the FFT capture path.
package fft_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_START = 2'd2,
        S_BUSY  = 2'd3
    } cap_state_t;

    localparam int WIDTH_DEF     = 8;
    localparam int FRAME_LEN_DEF = 64;
    localparam int DROP_W        = 16;

endpackage

// File: rtl/fft_capture_sequencer_ce_divider.sv
// ce_divider: free-running clock-enable divider.
// ce pulses once every CLK_DIV cycles while enabled.
module ce_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic ce
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // Phase counter; clear holds it at zero so a new run starts aligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign ce = enable && (cnt == LAST);

endmodule

// File: rtl/fft_capture_sequencer.sv
// fft_capture_sequencer: paces the decimator, fills one FFT frame, starts the FFT.
// Define DROP_CNT_EN to count samples discarded while the FFT is running.
module fft_capture_sequencer
    import fft_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int CLK_DIV   = 4,
    localparam int ADDR_W   = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              arm,
    input  logic              abort,
    input  logic              continuous,
    output logic              dec_ce,
    input  logic              dec_new_sample,
    input  logic [WIDTH-1:0]  dec_data,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [WIDTH-1:0]  buf_wdata,
    output logic              fft_start,
    input  logic              fft_done,
    output logic              busy,
    output logic [DROP_W-1:0] drop_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

    cap_state_t        state;
    logic [ADDR_W-1:0] ptr;

    // The divider keeps running outside FILL so the decimator phase is kept.
    ce_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (state != S_IDLE),
        .clear   (state == S_IDLE),
        .ce      (dec_ce)
    );

    // Capture FSM with registered write port, start pulse and busy flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            buf_we    <= 1'b0;
            buf_addr  <= '0;
            buf_wdata <= '0;
            fft_start <= 1'b0;
            busy      <= 1'b0;
        end else begin
            buf_we    <= 1'b0;
            fft_start <= 1'b0;
            if (abort) begin
                state <= S_IDLE;
                ptr   <= '0;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (arm) begin
                            state <= S_FILL;
                            ptr   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    S_FILL: begin
                        if (dec_new_sample) begin
                            buf_we    <= 1'b1;
                            buf_addr  <= ptr;
                            buf_wdata <= dec_data;
                            ptr       <= ptr + 1'b1;
                            if (ptr == LAST_ADDR) begin
                                state     <= S_START;
                                fft_start <= 1'b1;
                            end
                        end
                    end
                    S_START: begin
                        state <= S_BUSY;
                    end
                    S_BUSY: begin
                        if (fft_done) begin
                            ptr <= '0;
                            if (continuous) begin
                                state <= S_FILL;
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef DROP_CNT_EN
    logic [DROP_W-1:0] drop_q;
    logic              drop_hit;

    assign drop_hit = dec_new_sample &&
                      ((state == S_START) || (state == S_BUSY));

    // Saturating count of samples that arrive while the FFT owns the buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_q <= '0;
        end else if ((state == S_IDLE) && arm && !abort) begin
            drop_q <= '0;
        end else if (drop_hit && (drop_q != '1)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_fft_capture_sequencer.sv
// tb_fft_capture_sequencer: directed bench for the capture sequencer.
// u0 uses the default frame, u1 a 2-sample frame with CLK_DIV=1.
module tb_fft_capture_sequencer;

`ifdef DROP_CNT_EN
    localparam bit DROP_ON = 1'b1;
`else
    localparam bit DROP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // u0 signals
    logic        arm0, abort0, cont0, done0;
    logic        ce0, we0, start0, busy0;
    logic        nsa;
    logic [7:0]  da;
    logic [5:0]  addr0;
    logic [7:0]  wdata0;
    logic [15:0] drop0;

    // u1 signals
    logic        arm1, abort1, cont1, done1;
    logic        ce1, we1, start1, busy1;
    logic        ns1;
    logic [7:0]  d1v;
    logic [0:0]  addr1;
    logic [7:0]  wdata1;
    logic [15:0] drop1;

    fft_capture_sequencer #(
        .WIDTH (8), .FRAME_LEN (64), .CLK_DIV (4)
    ) u0 (
        .clk (clk), .reset_n (reset_n),
        .arm (arm0), .abort (abort0), .continuous (cont0),
        .dec_ce (ce0), .dec_new_sample (nsa), .dec_data (da),
        .buf_we (we0), .buf_addr (addr0), .buf_wdata (wdata0),
        .fft_start (start0), .fft_done (done0),
        .busy (busy0), .drop_count (drop0)
    );

    fft_capture_sequencer #(
        .WIDTH (8), .FRAME_LEN (2), .CLK_DIV (1)
    ) u1 (
        .clk (clk), .reset_n (reset_n),
        .arm (arm1), .abort (abort1), .continuous (cont1),
        .dec_ce (ce1), .dec_new_sample (ns1), .dec_data (d1v),
        .buf_we (we1), .buf_addr (addr1), .buf_wdata (wdata1),
        .fft_start (start1), .fft_done (done1),
        .busy (busy1), .drop_count (drop1)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Decimator model (TIMES=4): a sample after every 4th dec_ce.
    logic       mclr;
    logic [1:0] cecnt;
    logic [7:0] sctr;
    always @(posedge clk) begin
        if (mclr) begin
            cecnt <= 2'd0;
            sctr  <= 8'd0;
            nsa   <= 1'b0;
            da    <= 8'd0;
        end else begin
            nsa <= 1'b0;
            if (ce0) begin
                if (cecnt == 2'd3) begin
                    cecnt <= 2'd0;
                    nsa   <= 1'b1;
                    da    <= sctr ^ 8'h5A;
                    sctr  <= sctr + 8'd1;
                end else begin
                    cecnt <= cecnt + 2'd1;
                end
            end
        end
    end

    // Monitor for u0: write log, start count, drop window, dec_ce spacing.
    int qa[$];
    int qd[$];
    int starts = 0;
    int drops = 0;
    bit win = 1'b0;
    int cyc = 0;
    int last_ce = 0;
    bit prev_busy = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (we0) begin
            qa.push_back(int'(addr0));
            qd.push_back(int'(wdata0));
        end
        if (start0) begin
            starts++;
            win = 1'b1;
        end
        if (win && nsa) drops++;
        if (done0 || !busy0) win = 1'b0;
        if (busy0 && !prev_busy) last_ce = cyc - 1;
        if (!busy0) begin
            chk("ce_idle", ce0, 1'b0);
        end else if (ce0) begin
            chk("ce_gap", cyc - last_ce, 4);
            last_ce = cyc;
        end
        prev_busy = busy0;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic arm_u0();
        tick();
        arm0 = 1'b1;
        mclr = 1'b1;
        qa.delete();
        qd.delete();
        drops = 0;
        starts = 0;
        tick();
        arm0 = 1'b0;
        mclr = 1'b0;
    endtask

    task automatic pulse_done0();
        tick();
        done0 = 1'b1;
        tick();
        done0 = 1'b0;
    endtask

    task automatic pulse_abort0();
        tick();
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!start0 && n < budget);
        chk(tag, start0, 1'b1);
    endtask

    task automatic wait_writes(input string tag, input int cnt,
                               input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (qa.size() < cnt && n < budget);
        chk(tag, qa.size() >= cnt, 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int d1snap;
    int nw;

    initial begin
        reset_n = 1'b0;
        {arm0, abort0, cont0, done0} = '0;
        {arm1, abort1, cont1, done1} = '0;
        ns1 = 1'b0;
        d1v = 8'd0;
        mclr = 1'b1;
        #23;
        chk("rst_busy0", busy0, 1'b0);
        chk("rst_ce0", ce0, 1'b0);
        chk("rst_we0", we0, 1'b0);
        chk("rst_addr0", addr0, 6'd0);
        chk("rst_start0", start0, 1'b0);
        chk("rst_drop0", drop0, 16'd0);
        chk("rst_busy1", busy1, 1'b0);
        chk("rst_ce1", ce1, 1'b0);
        tick();
        reset_n = 1'b1;

        // 1: single frame, 64 writes, one start, busy until done
        arm_u0();
        wait_start("t1_start", 2000);
        tick();
        @(negedge clk);
        chk("t1_start_pulse", start0, 1'b0);
        chk("t1_nwrites", qa.size(), 64);
        for (int i = 0; i < 64; i++) begin
            chk("t1_addr", qa[i], i);
            chk("t1_data", qd[i], i ^ 'h5A);
        end
        chk("t1_starts", starts, 1);
        repeat (30) tick();
        @(negedge clk);
        chk("t1_busy_wait", busy0, 1'b1);
        chk("t1_no_drop_write", qa.size(), 64);
        pulse_done0();
        @(negedge clk);
        chk("t1_idle", busy0, 1'b0);
        tick();
        @(negedge clk);
        chk("t1_drop", drop0, DROP_ON ? drops : 0);

        // 2: continuous, done 100 cycles after start
        cont0 = 1'b1;
        arm_u0();
        wait_start("t2_start1", 2000);
        repeat (100) tick();
        done0 = 1'b1;
        tick();
        done0 = 1'b0;
        @(negedge clk);
        chk("t2_refill", busy0, 1'b1);
        d1snap = drops;
        wait_start("t2_start2", 2000);
        cont0 = 1'b0;
        tick();
        @(negedge clk);
        chk("t2_nwrites", qa.size(), 128);
        for (int i = 64; i < 128; i++) begin
            chk("t2_addr", qa[i], i - 64);
            chk("t2_data", qd[i] ^ 'h5A, (i + d1snap) & 'hFF);
        end
        chk("t2_starts", starts, 2);
        pulse_done0();
        @(negedge clk);
        chk("t2_idle", busy0, 1'b0);
        tick();
        @(negedge clk);
        chk("t2_drop", drop0, DROP_ON ? drops : 0);

        // 3: abort mid-fill, then re-arm from address 0
        arm_u0();
        wait_writes("t3_30", 30, 1000);
        pulse_abort0();
        @(negedge clk);
        chk("t3_idle", busy0, 1'b0);
        nw = qa.size();
        repeat (40) tick();
        @(negedge clk);
        chk("t3_no_write", qa.size(), nw);
        chk("t3_no_start", starts, 0);
        arm_u0();
        wait_writes("t3_rearm", 1, 200);
        chk("t3_addr0", qa[0], 0);
        chk("t3_data0", qd[0], 'h5A);
        pulse_abort0();

        // 4: fft_done in FILL and arm in BUSY are ignored
        arm_u0();
        wait_writes("t4_10", 10, 500);
        pulse_done0();
        wait_start("t4_start", 2000);
        tick();
        @(negedge clk);
        chk("t4_nwrites", qa.size(), 64);
        tick();
        arm0 = 1'b1;
        tick();
        arm0 = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        chk("t4_busy", busy0, 1'b1);
        chk("t4_no_write", qa.size(), 64);
        chk("t4_starts", starts, 1);
        pulse_done0();
        @(negedge clk);
        chk("t4_idle", busy0, 1'b0);
        repeat (5) tick();
        @(negedge clk);
        chk("t4_stay_idle", busy0, 1'b0);

        // 5: asynchronous reset mid-fill
        arm_u0();
        wait_writes("t5_5", 5, 500);
        @(negedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t5_busy", busy0, 1'b0);
        chk("t5_ce", ce0, 1'b0);
        chk("t5_addr", addr0, 6'd0);
        chk("t5_wdata", wdata0, 8'd0);
        chk("t5_start", start0, 1'b0);
        tick();
        reset_n = 1'b1;
        arm_u0();
        wait_writes("t5_rearm", 1, 200);
        chk("t5_addr0", qa[0], 0);
        chk("t5_data0", qd[0], 'h5A);
        pulse_abort0();

        // 6: CLK_DIV=1, FRAME_LEN=2
        tick();
        arm1 = 1'b1;
        tick();
        arm1 = 1'b0;
        @(negedge clk);
        chk("t6_ce_high", ce1, 1'b1);
        chk("t6_busy", busy1, 1'b1);
        tick();
        ns1 = 1'b1;
        d1v = 8'h11;
        tick();
        d1v = 8'h22;
        @(negedge clk);
        chk("t6_we_a", we1, 1'b1);
        chk("t6_addr_a", addr1, 1'b0);
        chk("t6_data_a", wdata1, 8'h11);
        tick();
        ns1 = 1'b0;
        @(negedge clk);
        chk("t6_we_b", we1, 1'b1);
        chk("t6_addr_b", addr1, 1'b1);
        chk("t6_data_b", wdata1, 8'h22);
        chk("t6_start", start1, 1'b1);
        chk("t6_ce_start", ce1, 1'b1);
        tick();
        ns1 = 1'b1;
        d1v = 8'h33;
        @(negedge clk);
        chk("t6_start_low", start1, 1'b0);
        chk("t6_busy_b", busy1, 1'b1);
        tick();
        ns1 = 1'b0;
        @(negedge clk);
        chk("t6_drop_nowrite", we1, 1'b0);
        chk("t6_drop_cnt", drop1, DROP_ON ? 16'd1 : 16'd0);
        tick();
        done1 = 1'b1;
        tick();
        done1 = 1'b0;
        @(negedge clk);
        chk("t6_idle", busy1, 1'b0);

        // abort wins over the final write
        tick();
        arm1 = 1'b1;
        tick();
        arm1 = 1'b0;
        ns1 = 1'b1;
        d1v = 8'h44;
        tick();
        abort1 = 1'b1;
        d1v = 8'h55;
        tick();
        abort1 = 1'b0;
        ns1 = 1'b0;
        @(negedge clk);
        chk("t6_ab_we", we1, 1'b0);
        chk("t6_ab_start", start1, 1'b0);
        chk("t6_ab_idle", busy1, 1'b0);
        chk("t6_arm_clr", drop1, 16'd0);
        tick();
        @(negedge clk);
        chk("t6_ab_start2", start1, 1'b0);

        // fft_done during START is ignored
        tick();
        arm1 = 1'b1;
        tick();
        arm1 = 1'b0;
        ns1 = 1'b1;
        d1v = 8'h01;
        tick();
        d1v = 8'h02;
        tick();
        ns1 = 1'b0;
        done1 = 1'b1;
        tick();
        done1 = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("t6_done_in_start", busy1, 1'b1);

`ifdef DROP_CNT_EN
        // long BUSY with a sample every cycle saturates the counter
        ns1 = 1'b1;
        repeat (65540) tick();
        ns1 = 1'b0;
        @(negedge clk);
        chk("t6_sat", drop1, 16'hFFFF);
`endif
        tick();
        done1 = 1'b1;
        tick();
        done1 = 1'b0;
        @(negedge clk);
        chk("t6_idle2", busy1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
